instr_sequencer: RTL and testbench

Parametrised instruction sequencer for the MSP430 core: owns the instruction register, extension-word capture, control-address register (CAR) stepping and interrupt entry, and feeds the combinational control decoder that maps CAR+IR to control words. It replaces the externally driven CAR/IR of the previous control unit with a state machine that handshakes with the memory interface and the execution datapath.

---
 rtl/instr_sequencer_pkg.sv | 74 +++++++
 rtl/instr_sequencer_irq_prio_enc.sv | 21 ++
 rtl/instr_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_instr_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared state/format encodings and IR field decode for the sequencer
package instr_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_RESET       = 4'd0,
        ST_FETCH       = 4'd1,
        ST_DECODE      = 4'd2,
        ST_SRC_EXT     = 4'd3,
        ST_DST_EXT     = 4'd4,
        ST_EXEC        = 4'd5,
        ST_INT_PUSH_PC = 4'd6,
        ST_INT_PUSH_SR = 4'd7,
        ST_INT_VECTOR  = 4'd8
    } seq_state_e;

    typedef enum logic [1:0] {
        FMT_TWO_OP  = 2'd0,
        FMT_ONE_OP  = 2'd1,
        FMT_JUMP    = 2'd2,
        FMT_ILLEGAL = 2'd3
    } fmt_e;

    localparam logic [3:0] TWO_OP_MIN_OPCODE = 4'd4;
    localparam logic [5:0] ONE_OP_PREFIX     = 6'b000100;
    localparam logic [2:0] JUMP_PREFIX       = 3'b001;
    localparam logic [1:0] AS_INDEXED        = 2'b01;
    localparam logic [1:0] AS_INDIRECT_INC   = 2'b11;
    localparam logic [3:0] REG_PC            = 4'd0;

    typedef struct packed {
        fmt_e       fmt;
        logic [3:0] src_a;
        logic [3:0] dst_a;
        logic [1:0] as_mode;
        logic       ad_mode;
    } ir_fields_t;

    // Jump and illegal words leave every register/mode field at zero.
    function automatic ir_fields_t decode_ir(input logic [15:0] ir);
        ir_fields_t f;
        f = '0;
        if (ir[15:12] >= TWO_OP_MIN_OPCODE) begin
            f.fmt     = FMT_TWO_OP;
            f.src_a   = ir[11:8];
            f.dst_a   = ir[3:0];
            f.as_mode = ir[5:4];
            f.ad_mode = ir[7];
        end else if (ir[15:10] == ONE_OP_PREFIX) begin
            f.fmt     = FMT_ONE_OP;
            f.src_a   = ir[3:0];
            f.dst_a   = ir[3:0];
            f.as_mode = ir[5:4];
        end else if (ir[15:13] == JUMP_PREFIX) begin
            f.fmt = FMT_JUMP;
        end else begin
            f.fmt = FMT_ILLEGAL;
        end
        return f;
    endfunction

    function automatic logic needs_src_ext(input ir_fields_t f);
        return (f.as_mode == AS_INDEXED) ||
               ((f.as_mode == AS_INDIRECT_INC) && (f.src_a == REG_PC));
    endfunction

    function automatic logic needs_dst_ext(input ir_fields_t f);
        return (f.fmt == FMT_TWO_OP) && f.ad_mode;
    endfunction

    function automatic logic is_fetch_state(input seq_state_e s);
        return (s == ST_FETCH) || (s == ST_SRC_EXT) || (s == ST_DST_EXT) || (s == ST_INT_VECTOR);
    endfunction

endpackage

// File: rtl/instr_sequencer_irq_prio_enc.sv
// rtl/instr_sequencer_irq_prio_enc.sv - fixed-priority encoder, highest set request index wins
module irq_prio_enc #(
    parameter  int NUM_IRQ = 4,
    localparam int IDW     = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic [IDW-1:0]     idx,
    output logic               any
);

    always_comb begin
        idx = '0;
        any = |req;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (req[i]) begin
                idx = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - instruction/extension fetch, CAR stepping and interrupt entry FSM
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter  int CAR_BITS = 6,
    parameter  int DATA_W   = 16,
    parameter  int NUM_IRQ  = 4,
    localparam int IRQ_IDW  = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic                MCLK,
    input  logic                reset_n,
    input  logic [DATA_W-1:0]   MDB_in,
    input  logic                mem_ready,
    input  logic                exec_done,
    input  logic                GIE,
    input  logic [NUM_IRQ-1:0]  IRQ,
    output logic                fetch_req,
    output logic [3:0]          state,
    output logic [CAR_BITS-1:0] CAR,
    output logic [DATA_W-1:0]   IR,
    output logic [DATA_W-1:0]   IW_src,
    output logic [DATA_W-1:0]   IW_dst,
    output logic [1:0]          Format,
    output logic [3:0]          srcA,
    output logic [3:0]          dstA,
    output logic [1:0]          As,
    output logic                Ad,
    output logic                instr_done,
    output logic                INTACK,
    output logic [IRQ_IDW-1:0]  irq_id
);

    seq_state_e          state_q, state_d;
    logic [CAR_BITS-1:0] car_q, car_d;
    logic [DATA_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0]   iw_src_q, iw_src_d;
    logic [DATA_W-1:0]   iw_dst_q, iw_dst_d;
    logic [IRQ_IDW-1:0]  irq_id_q, irq_id_d;
    logic                fetch_req_q, fetch_req_d;
    logic                instr_done_q, instr_done_d;
    logic                intack_q, intack_d;

    logic                advance;
    logic [IRQ_IDW-1:0]  irq_idx;
    logic                irq_any;
    ir_fields_t          fields;

    irq_prio_enc #(
        .NUM_IRQ (NUM_IRQ)
    ) u_irq_prio_enc (
        .req (IRQ),
        .idx (irq_idx),
        .any (irq_any)
    );

    assign fields = decode_ir(ir_q[15:0]);

    always_comb begin
        state_d      = state_q;
        car_d        = car_q;
        ir_d         = ir_q;
        iw_src_d     = iw_src_q;
        iw_dst_d     = iw_dst_q;
        irq_id_d     = irq_id_q;
        instr_done_d = 1'b0;
        intack_d     = 1'b0;
        advance      = 1'b0;

        case (state_q)
            ST_RESET: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (mem_ready) begin
                    ir_d    = MDB_in;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                advance = 1'b1;
                if (needs_src_ext(fields)) begin
                    state_d = ST_SRC_EXT;
                end else if (needs_dst_ext(fields)) begin
                    state_d = ST_DST_EXT;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_SRC_EXT: begin
                if (mem_ready) begin
                    iw_src_d = MDB_in;
                    advance  = 1'b1;
                    state_d  = needs_dst_ext(fields) ? ST_DST_EXT : ST_EXEC;
                end
            end
            ST_DST_EXT: begin
                if (mem_ready) begin
                    iw_dst_d = MDB_in;
                    advance  = 1'b1;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (exec_done) begin
                    instr_done_d = 1'b1;
                    advance      = 1'b1;
                    if (GIE && irq_any) begin
                        irq_id_d = irq_idx;
                        state_d  = ST_INT_PUSH_PC;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_INT_PUSH_PC: begin
                if (exec_done) begin
                    advance = 1'b1;
                    state_d = ST_INT_PUSH_SR;
                end
            end
            ST_INT_PUSH_SR: begin
                if (exec_done) begin
                    advance = 1'b1;
                    state_d = ST_INT_VECTOR;
                end
            end
            ST_INT_VECTOR: begin
                if (mem_ready) begin
                    intack_d = 1'b1;
                    advance  = 1'b1;
                    state_d  = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase

        // A new instruction word restarts the micro-step count; otherwise it saturates.
        if ((state_q == ST_FETCH) && mem_ready) begin
            car_d = '0;
        end else if (advance && (car_q != {CAR_BITS{1'b1}})) begin
            car_d = car_q + 1'b1;
        end

        fetch_req_d = is_fetch_state(state_d);
    end

    always_ff @(posedge MCLK) begin
        if (!reset_n) begin
            state_q      <= ST_RESET;
            car_q        <= '0;
            ir_q         <= '0;
            iw_src_q     <= '0;
            iw_dst_q     <= '0;
            irq_id_q     <= '0;
            fetch_req_q  <= 1'b0;
            instr_done_q <= 1'b0;
            intack_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            car_q        <= car_d;
            ir_q         <= ir_d;
            iw_src_q     <= iw_src_d;
            iw_dst_q     <= iw_dst_d;
            irq_id_q     <= irq_id_d;
            fetch_req_q  <= fetch_req_d;
            instr_done_q <= instr_done_d;
            intack_q     <= intack_d;
        end
    end

    assign state      = state_q;
    assign CAR        = car_q;
    assign IR         = ir_q;
    assign IW_src     = iw_src_q;
    assign IW_dst     = iw_dst_q;
    assign irq_id     = irq_id_q;
    assign fetch_req  = fetch_req_q;
    assign instr_done = instr_done_q;
    assign INTACK     = intack_q;
    assign Format     = fields.fmt;
    assign srcA       = fields.src_a;
    assign dstA       = fields.dst_a;
    assign As         = fields.as_mode;
    assign Ad         = fields.ad_mode;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer with directed instruction vectors
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    logic        MCLK = 1'b0;
    logic        reset_n;
    logic [15:0] MDB_in;
    logic        mem_ready, exec_done, GIE;
    logic [3:0]  IRQ;

    logic        fetch_req, instr_done, INTACK, Ad;
    logic [3:0]  state, srcA, dstA;
    logic [5:0]  CAR;
    logic [15:0] IR, IW_src, IW_dst;
    logic [1:0]  Format, As, irq_id;

    logic        u2_fetch_req, u2_instr_done, u2_INTACK, u2_Ad;
    logic [3:0]  u2_state, u2_srcA, u2_dstA;
    logic [1:0]  u2_CAR;
    logic [15:0] u2_IR, u2_IW_src, u2_IW_dst;
    logic [1:0]  u2_Format, u2_As, u2_irq_id;

    always #5 MCLK = ~MCLK;

    instr_sequencer dut (
        .MCLK(MCLK), .reset_n(reset_n), .MDB_in(MDB_in), .mem_ready(mem_ready),
        .exec_done(exec_done), .GIE(GIE), .IRQ(IRQ), .fetch_req(fetch_req),
        .state(state), .CAR(CAR), .IR(IR), .IW_src(IW_src), .IW_dst(IW_dst),
        .Format(Format), .srcA(srcA), .dstA(dstA), .As(As), .Ad(Ad),
        .instr_done(instr_done), .INTACK(INTACK), .irq_id(irq_id)
    );

    instr_sequencer #(.CAR_BITS(2)) dut_car2 (
        .MCLK(MCLK), .reset_n(reset_n), .MDB_in(MDB_in), .mem_ready(mem_ready),
        .exec_done(exec_done), .GIE(GIE), .IRQ(IRQ), .fetch_req(u2_fetch_req),
        .state(u2_state), .CAR(u2_CAR), .IR(u2_IR), .IW_src(u2_IW_src), .IW_dst(u2_IW_dst),
        .Format(u2_Format), .srcA(u2_srcA), .dstA(u2_dstA), .As(u2_As), .Ad(u2_Ad),
        .instr_done(u2_instr_done), .INTACK(u2_INTACK), .irq_id(u2_irq_id)
    );

    typedef struct {
        bit          is_ack;
        logic [15:0] ir, iws, iwd;
        logic [1:0]  fmt, as_m, irq;
        logic [3:0]  sa, da;
        logic        ad;
        int          gap;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] mem_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_evt = 0;
    int          exec_stall = 0;
    int          mem_stall = 0;
    logic [15:0] mem_stall_ir = 16'h0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endfunction

    task automatic push_instr(input logic [15:0] ir, input logic [1:0] fmt, input logic [3:0] sa,
                              input logic [3:0] da, input logic [1:0] as_m, input logic ad,
                              input logic [15:0] iws, input logic [15:0] iwd, input int gap);
        exp_t e;
        e.is_ack = 1'b0; e.ir = ir; e.fmt = fmt; e.sa = sa; e.da = da; e.as_m = as_m;
        e.ad = ad; e.iws = iws; e.iwd = iwd; e.irq = 2'd0; e.gap = gap;
        exp_q.push_back(e);
    endtask

    task automatic push_ack(input logic [1:0] irq, input int gap);
        exp_t e;
        e = '{is_ack: 1'b1, ir: 16'h0, iws: 16'h0, iwd: 16'h0, fmt: 2'd0, as_m: 2'd0,
              irq: irq, sa: 4'd0, da: 4'd0, ad: 1'b0, gap: gap};
        exp_q.push_back(e);
    endtask

    task automatic wait_for(input logic [3:0] st, input logic [15:0] ir, input int budget);
        int n = 0;
        do begin
            @(posedge MCLK); #1;
            n++;
        end while (!(state == st && IR == ir) && n < budget);
        chk("reach_state", {31'd0, (state == st && IR == ir)}, 32'd1);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge MCLK); #1;
            n++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    always @(posedge MCLK) cyc++;

    // Memory and datapath responders, driven away from the active edge.
    always @(negedge MCLK) begin
        if (fetch_req && mem_q.size() > 0 &&
            !(mem_stall > 0 && state == ST_SRC_EXT && IR == mem_stall_ir)) begin
            MDB_in    = mem_q.pop_front();
            mem_ready = 1'b1;
        end else begin
            mem_ready = 1'b0;
            MDB_in    = 16'hDEAD;
            if (fetch_req && mem_stall > 0 && state == ST_SRC_EXT && IR == mem_stall_ir)
                mem_stall--;
        end
        if (state == ST_EXEC || state == ST_INT_PUSH_PC || state == ST_INT_PUSH_SR) begin
            if (exec_stall > 0) begin
                exec_done = 1'b0;
                exec_stall--;
            end else begin
                exec_done = 1'b1;
            end
        end else begin
            exec_done = 1'b0;
        end
    end

    always @(negedge MCLK) begin
        exp_t e;
        if (reset_n && (instr_done || INTACK)) begin
            chk("pulse_excl", {31'd0, instr_done & INTACK}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {31'd0, INTACK}, {31'd0, instr_done});
            end else begin
                e = exp_q.pop_front();
                chk("kind", {31'd0, INTACK}, {31'd0, e.is_ack});
                if (!e.is_ack) begin
                    chk("IR", IR, e.ir);
                    chk("Format", Format, e.fmt);
                    chk("srcA", srcA, e.sa);
                    chk("dstA", dstA, e.da);
                    chk("As", As, e.as_m);
                    chk("Ad", Ad, e.ad);
                    chk("IW_src", IW_src, e.iws);
                    chk("IW_dst", IW_dst, e.iwd);
                end else begin
                    chk("irq_id", irq_id, e.irq);
                end
                if (e.gap != 0) chk("latency", cyc - last_evt, e.gap);
            end
            last_evt = cyc;
        end
    end

    initial begin
        reset_n = 1'b0; GIE = 1'b0; IRQ = 4'd0;
        MDB_in = 16'h0; mem_ready = 1'b0; exec_done = 1'b0;
        repeat (3) @(posedge MCLK);
        #1;
        chk("rst_state", state, ST_RESET);
        chk("rst_CAR", CAR, 0);
        chk("rst_IR", IR, 0);
        chk("rst_fetch_req", fetch_req, 0);
        chk("rst_pulses", {instr_done, INTACK}, 0);
        reset_n = 1'b1;
        @(posedge MCLK); #1;
        chk("post_rst_state", state, ST_FETCH);
        chk("post_rst_fetch_req", fetch_req, 1);

        mem_stall = 2; mem_stall_ir = 16'h5516;
        push_instr(16'h440A, 2'd0, 4'd4, 4'd10, 2'd0, 1'b0, 16'h0000, 16'h0000, 0);
        push_instr(16'h4034, 2'd0, 4'd0, 4'd4,  2'd3, 1'b0, 16'h1234, 16'h0000, 4);
        push_instr(16'h5516, 2'd0, 4'd5, 4'd6,  2'd1, 1'b0, 16'h0002, 16'h0000, 6);
        push_instr(16'h458B, 2'd0, 4'd5, 4'd11, 2'd0, 1'b1, 16'h0002, 16'h0000, 4);
        push_instr(16'h1107, 2'd1, 4'd7, 4'd7,  2'd0, 1'b0, 16'h0002, 16'h0000, 3);
        push_instr(16'h3C00, 2'd2, 4'd0, 4'd0,  2'd0, 1'b0, 16'h0002, 16'h0000, 3);
        push_instr(16'h0010, 2'd3, 4'd0, 4'd0,  2'd0, 1'b0, 16'h0002, 16'h0000, 3);
        mem_q = '{16'h440A, 16'h4034, 16'h1234, 16'h5516, 16'h0002, 16'h458B, 16'h0000,
                  16'h1107, 16'h3C00, 16'h0010};
        wait_for(ST_SRC_EXT, 16'h5516, 200);
        chk("stall_CAR0", CAR, 1);
        @(posedge MCLK); #1;
        chk("stall_hold1", state, ST_SRC_EXT);
        chk("stall_CAR1", CAR, 1);
        @(posedge MCLK); #1;
        chk("stall_hold2", state, ST_SRC_EXT);
        @(posedge MCLK); #1;
        chk("stall_exit", state, ST_EXEC);
        chk("stall_exit_CAR", CAR, 2);
        wait_drain(300);

        GIE = 1'b1; IRQ = 4'b1010;
        push_instr(16'h440A, 2'd0, 4'd4, 4'd10, 2'd0, 1'b0, 16'h0002, 16'h0000, 0);
        push_ack(2'd3, 3);
        mem_q = '{16'h440A, 16'hFFF0};
        wait_for(ST_INT_PUSH_PC, 16'h440A, 100);
        IRQ = 4'b0000;
        wait_drain(100);

        GIE = 1'b0; IRQ = 4'b1010;
        push_instr(16'h1107, 2'd1, 4'd7, 4'd7, 2'd0, 1'b0, 16'h0002, 16'h0000, 0);
        push_instr(16'h3C00, 2'd2, 4'd0, 4'd0, 2'd0, 1'b0, 16'h0002, 16'h0000, 3);
        mem_q = '{16'h1107, 16'h3C00};
        wait_drain(100);
        chk("gie0_no_entry", state, ST_FETCH);
        IRQ = 4'b0000;

        exec_stall = 3;
        push_instr(16'h4592, 2'd0, 4'd5, 4'd2, 2'd1, 1'b1, 16'h0004, 16'h0006, 0);
        mem_q = '{16'h4592, 16'h0004, 16'h0006};
        wait_for(ST_EXEC, 16'h4592, 100);
        chk("exec_CAR6", CAR, 3);
        chk("exec_CAR2", u2_CAR, 3);
        wait_for(ST_FETCH, 16'h4592, 100);
        chk("next_CAR6", CAR, 4);
        chk("sat_CAR2", u2_CAR, 3);
        chk("car2_state", u2_state, ST_FETCH);
        wait_drain(100);

        exec_stall = 1000;
        mem_q = '{16'h458B, 16'h0040};
        wait_for(ST_EXEC, 16'h458B, 100);
        chk("pre_rst_IW_dst", IW_dst, 16'h0040);
        reset_n = 1'b0;
        @(posedge MCLK); #1;
        chk("mid_rst_state", state, ST_RESET);
        chk("mid_rst_CAR", CAR, 0);
        chk("mid_rst_IR", IR, 0);
        chk("mid_rst_IW", {IW_src, IW_dst}, 0);
        chk("mid_rst_irq_id", irq_id, 0);
        chk("mid_rst_outs", {fetch_req, instr_done, INTACK}, 0);
        exec_stall = 0;
        reset_n = 1'b1;
        @(posedge MCLK); #1;
        chk("mid_rst_fetch", state, ST_FETCH);
        repeat (4) @(posedge MCLK);
        #1;
        chk("exp_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
